ireorder_addr_gen: RTL and testbench

IREORDER_ADDR_GEN -- requirements
Module: ireorder_addr_gen

---
 rtl/ireorder_addr_gen_if.sv | 34 +++
 rtl/ireorder_addr_gen.sv | 118 +++++++++++
 tb/tb_ireorder_addr_gen.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ireorder_addr_gen_if.sv
// Handshake/address bundle between the inverse-reorder address generator and its controller.
// The controller drives start_i/hold_i; the generator drives the address outputs.
interface ireorder_addr_gen_if #(
    parameter int IRAG_WIDTH    = 11,
    parameter int IRAG_BN_WIDTH = 5
) ();
    logic                     start_i;
    logic                     hold_i;
    logic [IRAG_WIDTH-1:0]    MA_o;
    logic [IRAG_BN_WIDTH-1:0] BN_o;
    logic                     valid_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i,
        output hold_i,
        input  MA_o,
        input  BN_o,
        input  valid_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  hold_i,
        output MA_o,
        output BN_o,
        output valid_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/ireorder_addr_gen.sv
// Inverse-reorder address generator: walks a point counter, digit-reverses it (radix 16)
// and emits the row address plus a skewed bank index, one address per unstalled cycle.
module ireorder_addr_gen #(
    parameter int IRAG_WIDTH     = 11,
    parameter int IRAG_CNT_WIDTH = 16,
    parameter int IRAG_BN_WIDTH  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    ireorder_addr_gen_if.slave  irag
);
    localparam int CW = IRAG_CNT_WIDTH;
    localparam int DIGITS = CW / 4;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Base-16 digit reversal: the lowest digit of the count becomes the highest of the index.
    function automatic logic [CW-1:0] digit_rev(input logic [CW-1:0] c);
        logic [CW-1:0] r;
        r = CNT_ZERO;
        for (int d = 0; d < DIGITS; d++) begin
            r[(DIGITS-1-d)*4 +: 4] = c[d*4 +: 4];
        end
        return r;
    endfunction

    // Bank skew: folding the 5-bit slices of the reversed index spreads each row across banks.
    function automatic logic [IRAG_BN_WIDTH-1:0] bank_of(input logic [CW-1:0] r);
        logic [IRAG_BN_WIDTH-1:0] s;
        s = r[4:0] + r[9:5] + r[14:10] + {4'b0000, r[15]};
        return s;
    endfunction

    state_t                   state_r, state_s;
    logic [CW-1:0]            cnt_r, cnt_s;
    logic [CW-1:0]            rev_s;
    logic [IRAG_WIDTH-1:0]    ma_r, ma_s;
    logic [IRAG_BN_WIDTH-1:0] bn_r, bn_s;
    logic                     valid_r, valid_s;
    logic                     done_r, done_s;

    // Next-state and next-output decode for the pass sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        ma_s    = ma_r;
        bn_s    = bn_r;
        valid_s = 1'b0;
        done_s  = 1'b0;
        rev_s   = digit_rev(cnt_r);
        case (state_r)
            ST_IDLE: begin
                if (irag.start_i) begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!irag.hold_i) begin
                    ma_s    = rev_s[CW-1 -: IRAG_WIDTH];
                    bn_s    = bank_of(rev_s);
                    valid_s = 1'b1;
                    cnt_s   = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // The done pulse is registered here so it lands right after the last address.
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            ma_r    <= {IRAG_WIDTH{1'b0}};
            bn_r    <= {IRAG_BN_WIDTH{1'b0}};
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ma_r    <= ma_s;
            bn_r    <= bn_s;
            valid_r <= valid_s;
            done_r  <= done_s;
        end
    end

    assign irag.MA_o    = ma_r;
    assign irag.BN_o    = bn_r;
    assign irag.valid_o = valid_r;
    assign irag.done_o  = done_r;
    assign irag.busy_o  = (state_r != ST_IDLE);
endmodule

// File: tb/tb_ireorder_addr_gen.sv
// Self-checking bench for ireorder_addr_gen: scoreboard of digit-reversed addresses per pass.
module tb_ireorder_addr_gen;
    localparam int AW = 11;
    localparam int BW = 5;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ireorder_addr_gen_if #(.IRAG_WIDTH(AW), .IRAG_BN_WIDTH(BW)) bus ();
    ireorder_addr_gen #(.IRAG_WIDTH(AW), .IRAG_CNT_WIDTH(CW), .IRAG_BN_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .irag  (bus)
    );

    typedef struct packed {
        logic [15:0] cnt;
        logic [10:0] ma;
        logic [4:0]  bn;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   cov [0:65535];

    function automatic exp_t model(input int c);
        exp_t m;
        int   r;
        int   s;
        r = 0;
        for (int d = 0; d < 4; d++) r = r | (((c >> (4 * d)) & 15) << (4 * (3 - d)));
        s = (r & 31) + ((r >> 5) & 31) + ((r >> 10) & 31) + ((r >> 15) & 1);
        m.cnt = c[15:0];
        m.ma  = r[15:5];
        m.bn  = s[4:0];
        return m;
    endfunction

    task automatic push_entries(input int n);
        for (int i = 0; i < n; i++) sb.push_back(model(i));
    endtask

    task automatic test_reset();
        bus.start_i = 1'b0;
        bus.hold_i  = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.MA_o, bus.BN_o, bus.valid_o, bus.busy_o, bus.done_o} !== 19'd0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0", {bus.MA_o, bus.BN_o, bus.valid_o, bus.busy_o, bus.done_o});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus.hold_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.MA_o, bus.BN_o, bus.valid_o, bus.busy_o, bus.done_o} !== 19'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected 0", {bus.MA_o, bus.BN_o, bus.valid_o, bus.busy_o, bus.done_o});
        end
        bus.hold_i = 1'b0;
    endtask

    task automatic test_first_values_and_abort();
        exp_t e;
        int   vcount;
        sb.delete();
        push_entries(1100);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL start_accept: got valid=%b busy=%b expected valid=0 busy=1", bus.valid_o, bus.busy_o);
        end
        vcount = 0;
        for (int cyc = 0; cyc < 1100 && vcount < 1000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (bus.valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL first_valid_latency: got valid=%b expected 1", bus.valid_o);
                end
            end
            if (bus.valid_o === 1'b1) begin
                e = sb.pop_front();
                checks++;
                if ({bus.MA_o, bus.BN_o} !== {e.ma, e.bn}) begin
                    errors++;
                    $display("FAIL addr_cnt%0d: got MA=%h BN=%0d expected MA=%h BN=%0d", e.cnt, bus.MA_o, bus.BN_o, e.ma, e.bn);
                end
                if (vcount == 0) begin
                    checks++;
                    if (bus.MA_o !== 11'h000 || bus.BN_o !== 5'd0) begin
                        errors++;
                        $display("FAIL cnt0_const: got MA=%h BN=%0d expected MA=000 BN=0", bus.MA_o, bus.BN_o);
                    end
                end
                if (vcount == 1) begin
                    checks++;
                    if (bus.MA_o !== 11'h080 || bus.BN_o !== 5'd4) begin
                        errors++;
                        $display("FAIL cnt1_const: got MA=%h BN=%0d expected MA=080 BN=4", bus.MA_o, bus.BN_o);
                    end
                end
                vcount++;
            end
        end
        checks++;
        if (vcount != 1000) begin
            errors++;
            $display("FAIL pre_abort_count: got %0d expected 1000", vcount);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.MA_o, bus.BN_o, bus.valid_o, bus.busy_o, bus.done_o} !== 19'd0) begin
            errors++;
            $display("FAIL abort_async: got %h expected 0", {bus.MA_o, bus.BN_o, bus.valid_o, bus.busy_o, bus.done_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.valid_o, bus.busy_o, bus.done_o} !== 3'b000) begin
                errors++;
                $display("FAIL abort_no_restart: got %b expected 000", {bus.valid_o, bus.busy_o, bus.done_o});
            end
        end
        sb.delete();
    endtask

    task automatic test_full_pass_random_hold();
        exp_t        e;
        int          vcount;
        int          dcount;
        int          covered;
        bit          hold_prev;
        bit          prev_valid;
        logic [10:0] last_ma;
        logic [4:0]  last_bn;
        logic [15:0] idx;
        sb.delete();
        for (int i = 0; i < 65536; i++) cov[i] = 1'b0;
        push_entries(65536);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        vcount = 0;
        dcount = 0;
        hold_prev = 1'b0;
        prev_valid = 1'b0;
        last_ma = bus.MA_o;
        last_bn = bus.BN_o;
        for (int cyc = 0; cyc < 80000 && dcount == 0; cyc++) begin
            @(negedge clk);
            if (hold_prev && vcount > 0) begin
                checks++;
                if (bus.valid_o !== 1'b0 || {bus.MA_o, bus.BN_o} !== {last_ma, last_bn}) begin
                    errors++;
                    $display("FAIL hold_freeze: got valid=%b MA=%h BN=%0d expected valid=0 MA=%h BN=%0d", bus.valid_o, bus.MA_o, bus.BN_o, last_ma, last_bn);
                end
            end
            if (bus.valid_o === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_valid: got valid beyond pass expected none");
                end else begin
                    e = sb.pop_front();
                    idx = {bus.MA_o, bus.BN_o};
                    if ({bus.MA_o, bus.BN_o} !== {e.ma, e.bn}) begin
                        errors++;
                        $display("FAIL addr_cnt%0d: got MA=%h BN=%0d expected MA=%h BN=%0d", e.cnt, bus.MA_o, bus.BN_o, e.ma, e.bn);
                    end else if (cov[idx]) begin
                        errors++;
                        $display("FAIL duplicate_pair: got MA=%h BN=%0d again expected once", bus.MA_o, bus.BN_o);
                    end
                    cov[idx] = 1'b1;
                    if (e.cnt == 16'h0012) begin
                        checks++;
                        if (bus.MA_o !== 11'h108 || bus.BN_o !== 5'd16) begin
                            errors++;
                            $display("FAIL cnt0012_const: got MA=%h BN=%0d expected MA=108 BN=16", bus.MA_o, bus.BN_o);
                        end
                    end
                    if (e.cnt == 16'hFFFF) begin
                        checks++;
                        if (bus.MA_o !== 11'h7FF || bus.BN_o !== 5'd30) begin
                            errors++;
                            $display("FAIL cntffff_const: got MA=%h BN=%0d expected MA=7ff BN=30", bus.MA_o, bus.BN_o);
                        end
                    end
                end
                vcount++;
            end
            if (bus.done_o === 1'b1) begin
                dcount++;
                checks++;
                if (prev_valid !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL done_timing: got prev_valid=%b valid=%b busy=%b expected 1 0 0", prev_valid, bus.valid_o, bus.busy_o);
                end
            end
            last_ma = bus.MA_o;
            last_bn = bus.BN_o;
            prev_valid = bus.valid_o;
            if (dcount == 0) begin
                bus.hold_i  = (cyc >= 500 && cyc <= 502) ? 1'b1 : ($urandom_range(15) == 0);
                bus.start_i = (cyc == 2000 || cyc == 30000) ? 1'b1 : 1'b0;
                hold_prev   = bus.hold_i;
            end
        end
        covered = 0;
        for (int i = 0; i < 65536; i++) covered += int'(cov[i]);
        checks++;
        if (dcount != 1) begin
            errors++;
            $display("FAIL done_count: got %0d expected 1", dcount);
        end
        checks++;
        if (vcount != 65536 || sb.size() != 0) begin
            errors++;
            $display("FAIL pass_length: got %0d left %0d expected 65536 left 0", vcount, sb.size());
        end
        checks++;
        if (covered != 65536) begin
            errors++;
            $display("FAIL pair_coverage: got %0d expected 65536", covered);
        end
    endtask

    task automatic test_restart_after_done();
        exp_t e;
        int   vcount;
        sb.delete();
        push_entries(4);
        bus.hold_i  = 1'b0;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        checks++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL restart_accept: got done=%b busy=%b expected done=0 busy=1", bus.done_o, bus.busy_o);
        end
        vcount = 0;
        for (int cyc = 0; cyc < 10 && vcount < 4; cyc++) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) begin
                e = sb.pop_front();
                checks++;
                if ({bus.MA_o, bus.BN_o} !== {e.ma, e.bn}) begin
                    errors++;
                    $display("FAIL restart_cnt%0d: got MA=%h BN=%0d expected MA=%h BN=%0d", e.cnt, bus.MA_o, bus.BN_o, e.ma, e.bn);
                end
                vcount++;
            end
        end
        checks++;
        if (vcount != 4) begin
            errors++;
            $display("FAIL restart_count: got %0d expected 4", vcount);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.hold_i  = 1'b0;
        test_reset();
        test_first_values_and_abort();
        test_full_pass_random_hold();
        test_restart_after_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
